// File: rtl/text_dma_pkg.sv
// text_dma_pkg: shared definitions for the text-window DMA engine.
//   - register offsets relative to BASE
//   - CTRL bit positions
//   - engine state encoding
//   - wrapping address increment helper
package text_dma_pkg;

  // Width of the SRC/DST/LEN programming registers (low byte plus a 4-bit high nibble).
  localparam int unsigned RegW = 12;

  // Register offsets inside the 8-byte I/O window.
  localparam logic [2:0] RegSrcL = 3'd0;
  localparam logic [2:0] RegSrcH = 3'd1;
  localparam logic [2:0] RegDstL = 3'd2;
  localparam logic [2:0] RegDstH = 3'd3;
  localparam logic [2:0] RegLenL = 3'd4;
  localparam logic [2:0] RegLenH = 3'd5;
  localparam logic [2:0] RegFill = 3'd6;
  localparam logic [2:0] RegCtrl = 3'd7;

  // CTRL write bits.
  localparam int unsigned CtrlCopyBit  = 0;
  localparam int unsigned CtrlFillBit  = 1;
  localparam int unsigned CtrlAbortBit = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2,
    StFill = 2'd3
  } state_e;

  // Increment an address and wrap it to the text window size given by mask.
  function automatic logic [RegW-1:0] addr_inc(input logic [RegW-1:0] addr,
                                               input logic [RegW-1:0] mask);
    return (addr + 1'b1) & mask;
  endfunction

endpackage

// File: rtl/text_dma.sv
// text_dma: byte copy / fill engine sharing a single-port text memory with the CPU.
//
// Ports
//   clock, reset_n          system clock, synchronous active-low reset
//   io_address/io_wren/     CPU I/O bus; registers live at BASE..BASE+7
//   io_data/io_rdata/io_hit io_data is also the CPU write data for the text window
//   cpu_req/cpu_addr/       CPU text-window access; the CPU always wins the memory port
//   cpu_wren
//   mem_addr/mem_wdata/     text memory port (combinational mux CPU vs engine);
//   mem_wren/mem_rdata      mem_rdata is valid one cycle after the address is sampled
//   busy                    engine is not idle
//   done                    one-cycle pulse on completion, zero-length start, or abort
//
// Copy runs RD -> WR per byte (2 cycles/byte), fill writes one byte per cycle. The engine
// simply holds its state in any cycle where cpu_req is high.
module text_dma
  import text_dma_pkg::*;
#(
  parameter logic [7:0]  BASE = 8'h30,
  parameter int unsigned AW   = 12     // must not exceed RegW
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [15:0]   io_address,
  input  logic          io_wren,
  input  logic [7:0]    io_data,
  output logic [7:0]    io_rdata,
  output logic          io_hit,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_wren,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_wren,
  input  logic [7:0]    mem_rdata,
  output logic          busy,
  output logic          done
);

  // Keeps src/dst increments inside the 2^AW window.
  localparam logic [RegW-1:0] AddrMask = {RegW{1'b1}} >> (RegW - AW);

  state_e          state_q;
  logic [RegW-1:0] src_q;
  logic [RegW-1:0] dst_q;
  logic [RegW-1:0] len_q;
  logic [7:0]      fill_q;
  logic [7:0]      hold_q;
  logic            wr_first_q;
  logic            done_q;

  logic [15:0]     io_offset;
  logic [2:0]      reg_sel;
  logic            reg_wr;
  logic            ctrl_wr;
  logic            start_copy;
  logic            start_fill;
  logic            abort_req;
  logic            cpu_owns;

  // Register decode and CTRL command qualification.
  always_comb begin
    io_offset  = io_address - {8'h00, BASE};
    io_hit     = (io_offset < 16'd8);
    reg_sel    = io_offset[2:0];
    reg_wr     = io_hit && io_wren;
    ctrl_wr    = reg_wr && (reg_sel == RegCtrl);
    busy       = (state_q != StIdle);
    // Copy takes precedence when both start bits are set.
    start_copy = ctrl_wr && !busy && io_data[CtrlCopyBit];
    start_fill = ctrl_wr && !busy && !io_data[CtrlCopyBit] && io_data[CtrlFillBit];
    abort_req  = ctrl_wr && busy && io_data[CtrlAbortBit];
    done       = done_q;
  end

  // Register read mux.
  always_comb begin
    io_rdata = 8'h00;
    if (io_hit) begin
      unique case (reg_sel)
        RegSrcL: io_rdata = src_q[7:0];
        RegSrcH: io_rdata = {4'h0, src_q[RegW-1:8]};
        RegDstL: io_rdata = dst_q[7:0];
        RegDstH: io_rdata = {4'h0, dst_q[RegW-1:8]};
        RegLenL: io_rdata = len_q[7:0];
        RegLenH: io_rdata = {4'h0, len_q[RegW-1:8]};
        RegFill: io_rdata = fill_q;
        RegCtrl: io_rdata = {7'b0, busy};
        default: io_rdata = 8'h00;
      endcase
    end
  end

  // Memory port arbitration: the CPU owns the port whenever the engine is idle or the
  // CPU requests it. In the abort cycle the engine keeps the port but writes nothing.
  always_comb begin
    cpu_owns  = !busy || cpu_req;
    mem_addr  = cpu_addr;
    mem_wdata = io_data;
    mem_wren  = cpu_wren;
    if (!cpu_owns) begin
      unique case (state_q)
        StRd: begin
          mem_addr  = src_q[AW-1:0];
          mem_wdata = 8'h00;
          mem_wren  = 1'b0;
        end
        StWr: begin
          mem_addr  = dst_q[AW-1:0];
          // The read data is still on mem_rdata in the first WR cycle, so bypass the
          // hold register; afterwards (after a CPU stall) use the captured byte.
          mem_wdata = wr_first_q ? mem_rdata : hold_q;
          mem_wren  = !abort_req;
        end
        StFill: begin
          mem_addr  = dst_q[AW-1:0];
          mem_wdata = fill_q;
          mem_wren  = !abort_req;
        end
        default: begin
          mem_addr  = cpu_addr;
          mem_wdata = io_data;
          mem_wren  = cpu_wren;
        end
      endcase
    end
  end

  // Register file and engine FSM.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      fill_q     <= 8'h00;
      hold_q     <= 8'h00;
      wr_first_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Programming registers are frozen while a transfer is running.
      if (reg_wr && !busy) begin
        unique case (reg_sel)
          RegSrcL: src_q[7:0]      <= io_data;
          RegSrcH: src_q[RegW-1:8] <= io_data[3:0];
          RegDstL: dst_q[7:0]      <= io_data;
          RegDstH: dst_q[RegW-1:8] <= io_data[3:0];
          RegLenL: len_q[7:0]      <= io_data;
          RegLenH: len_q[RegW-1:8] <= io_data[3:0];
          RegFill: fill_q          <= io_data;
          default: ;  // CTRL is a command, handled below
        endcase
      end

      unique case (state_q)
        StIdle: begin
          if (start_copy || start_fill) begin
            if (len_q == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= start_copy ? StRd : StFill;
            end
          end
        end

        StRd: begin
          if (abort_req) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else if (!cpu_req) begin
            state_q    <= StWr;
            wr_first_q <= 1'b1;
          end
        end

        StWr: begin
          // Capture the read byte regardless of grant so a CPU stall cannot lose it.
          if (wr_first_q) begin
            hold_q     <= mem_rdata;
            wr_first_q <= 1'b0;
          end
          if (abort_req) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else if (!cpu_req) begin
            src_q <= addr_inc(src_q, AddrMask);
            dst_q <= addr_inc(dst_q, AddrMask);
            len_q <= len_q - 1'b1;
            if (len_q == {{(RegW-1){1'b0}}, 1'b1}) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRd;
            end
          end
        end

        StFill: begin
          if (abort_req) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else if (!cpu_req) begin
            dst_q <= addr_inc(dst_q, AddrMask);
            len_q <= len_q - 1'b1;
            if (len_q == {{(RegW-1){1'b0}}, 1'b1}) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_text_dma.sv
// Directed self-checking bench for text_dma with a 4 KB synchronous-read memory model.
module tb_text_dma;

  localparam logic [7:0] Base = 8'h30;
  localparam int unsigned Aw  = 12;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [15:0]   io_address;
  logic          io_wren;
  logic [7:0]    io_data;
  logic [7:0]    io_rdata;
  logic          io_hit;
  logic          cpu_req;
  logic [Aw-1:0] cpu_addr;
  logic          cpu_wren;
  logic [Aw-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_wren;
  logic [7:0]    mem_rdata;
  logic          busy;
  logic          done;

  logic [7:0]    ram [4096];
  logic          init_req;
  int            n_checks;
  int            n_pass;

  text_dma #(.BASE(Base), .AW(Aw)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .io_address (io_address),
    .io_wren    (io_wren),
    .io_data    (io_data),
    .io_rdata   (io_rdata),
    .io_hit     (io_hit),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_wren   (cpu_wren),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wren   (mem_wren),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) ^ (i >> 5));
  endfunction

  // Memory model: registered read data, read-before-write.
  always @(posedge clock) begin
    if (init_req) begin
      for (int i = 0; i < 4096; i++) ram[i] <= pat(i);
    end else if (mem_wren) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic load_pattern();
    @(negedge clock);
    init_req = 1'b1;
    @(negedge clock);
    init_req = 1'b0;
  endtask

  task automatic io_write(input logic [2:0] off, input logic [7:0] d);
    @(negedge clock);
    io_address = {8'h00, Base} + {13'h0, off};
    io_data    = d;
    io_wren    = 1'b1;
    @(negedge clock);
    io_wren    = 1'b0;
  endtask

  task automatic io_read(input logic [2:0] off, output logic [7:0] d);
    io_wren    = 1'b0;
    io_address = {8'h00, Base} + {13'h0, off};
    #1;
    d = io_rdata;
  endtask

  task automatic set_regs(input logic [11:0] src, input logic [11:0] dst,
                          input logic [11:0] len, input logic [7:0] fill);
    io_write(3'd0, src[7:0]);
    io_write(3'd1, {4'h0, src[11:8]});
    io_write(3'd2, dst[7:0]);
    io_write(3'd3, {4'h0, dst[11:8]});
    io_write(3'd4, len[7:0]);
    io_write(3'd5, {4'h0, len[11:8]});
    io_write(3'd6, fill);
  endtask

  // Returns the number of negedges waited until done was seen (limit on timeout).
  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    for (int r = 0; r < 8; r++) begin
      io_read(3'(r), d);
      n_checks++;
      if (d !== 8'h00) $display("FAIL reset_reg%0d: got %h want 00", r, d); else n_pass++;
    end
    io_address = 16'h0037; #1;
    n_checks++;
    if (io_hit !== 1'b1) $display("FAIL hit_top: got %b want 1", io_hit); else n_pass++;
    io_address = 16'h0038; #1;
    n_checks++;
    if (io_hit !== 1'b0) $display("FAIL hit_above: got %b want 0", io_hit); else n_pass++;
    io_address = 16'h002F; #1;
    n_checks++;
    if (io_hit !== 1'b0) $display("FAIL hit_below: got %b want 0", io_hit); else n_pass++;
    cpu_addr = 12'h123; cpu_wren = 1'b1; cpu_req = 1'b0; #1;
    n_checks++;
    if (mem_addr !== 12'h123 || mem_wren !== 1'b1)
      $display("FAIL idle_passthru: got addr %h wren %b want 123 1", mem_addr, mem_wren);
    else n_pass++;
    cpu_wren = 1'b0;
  endtask

  task automatic test_regs();
    logic [7:0] d;
    io_write(3'd0, 8'hAB);
    io_write(3'd1, 8'hFC);
    io_write(3'd5, 8'h5A);
    io_write(3'd6, 8'h3C);
    io_read(3'd0, d);
    n_checks++;
    if (d !== 8'hAB) $display("FAIL src_l_rb: got %h want ab", d); else n_pass++;
    io_read(3'd1, d);
    n_checks++;
    if (d !== 8'h0C) $display("FAIL src_h_rb: got %h want 0c", d); else n_pass++;
    io_read(3'd5, d);
    n_checks++;
    if (d !== 8'h0A) $display("FAIL len_h_rb: got %h want 0a", d); else n_pass++;
    io_read(3'd6, d);
    n_checks++;
    if (d !== 8'h3C) $display("FAIL fill_rb: got %h want 3c", d); else n_pass++;
  endtask

  task automatic test_len_zero();
    set_regs(12'h000, 12'h000, 12'h000, 8'h00);
    io_write(3'd7, 8'h02);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL len0_done: got done %b busy %b want 1 0", done, busy);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if (done !== 1'b0) $display("FAIL len0_pulse: got %b want 0", done); else n_pass++;
  endtask

  task automatic test_fill();
    int n;
    int errs;
    logic [7:0] d;
    load_pattern();
    set_regs(12'h000, 12'h000, 12'd80, 8'h20);
    io_write(3'd7, 8'h02);
    io_read(3'd7, d);
    n_checks++;
    if (d !== 8'h01) $display("FAIL fill_ctrl_busy: got %h want 01", d); else n_pass++;
    wait_done(200, n);
    n_checks++;
    if (n !== 80) $display("FAIL fill_cycles: got %0d want 80", n); else n_pass++;
    @(negedge clock);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL fill_end: got done %b busy %b want 0 0", done, busy);
    else n_pass++;
    errs = 0;
    for (int i = 0; i < 80; i++) if (ram[i] !== 8'h20) errs++;
    if (ram[80] !== pat(80)) errs++;
    n_checks++;
    if (errs != 0) $display("FAIL fill_mem: got %0d bad bytes want 0", errs); else n_pass++;
    io_read(3'd2, d);
    n_checks++;
    if (d !== 8'h50) $display("FAIL fill_dst: got %h want 50", d); else n_pass++;
  endtask

  task automatic test_copy();
    int n;
    int errs;
    load_pattern();
    set_regs(12'h050, 12'h000, 12'd3920, 8'h00);
    io_write(3'd7, 8'h01);
    wait_done(9000, n);
    n_checks++;
    if (n !== 7840) $display("FAIL copy_cycles: got %0d want 7840", n); else n_pass++;
    n_checks++;
    if (ram[0] !== pat(80)) $display("FAIL copy_first: got %h want %h", ram[0], pat(80));
    else n_pass++;
    errs = 0;
    for (int i = 0; i < 4096; i++)
      if (ram[i] !== ((i < 3920) ? pat(i + 80) : pat(i))) errs++;
    n_checks++;
    if (errs != 0) $display("FAIL copy_mem: got %0d bad bytes want 0", errs); else n_pass++;
  endtask

  task automatic test_copy_contended();
    int n;
    int errs;
    int viol;
    bit stop;
    load_pattern();
    set_regs(12'h050, 12'h000, 12'd3920, 8'h00);
    io_write(3'd7, 8'h01);
    stop = 1'b0;
    viol = 0;
    fork
      begin
        int k = 0;
        while (!stop) begin
          @(negedge clock);
          k++;
          cpu_req  = k[0];
          cpu_wren = 1'b0;
          cpu_addr = 12'(k * 13);
          #1;
          if (cpu_req && (mem_addr !== cpu_addr || mem_wren !== 1'b0)) viol++;
        end
        cpu_req = 1'b0;
      end
      begin
        wait_done(20000, n);
        stop = 1'b1;
      end
    join
    n_checks++;
    if (n >= 20000) $display("FAIL contend_timeout: got %0d cycles want <20000", n);
    else n_pass++;
    n_checks++;
    if (viol != 0) $display("FAIL contend_cpu_port: got %0d bad cycles want 0", viol);
    else n_pass++;
    errs = 0;
    for (int i = 0; i < 4096; i++)
      if (ram[i] !== ((i < 3920) ? pat(i + 80) : pat(i))) errs++;
    n_checks++;
    if (errs != 0) $display("FAIL contend_mem: got %0d bad bytes want 0", errs); else n_pass++;
  endtask

  task automatic test_wrap();
    int n;
    int errs;
    logic [7:0] d;
    load_pattern();
    set_regs(12'h000, 12'hFFE, 12'd4, 8'hC3);
    io_write(3'd7, 8'h02);
    wait_done(50, n);
    n_checks++;
    if (n !== 4) $display("FAIL wrap_cycles: got %0d want 4", n); else n_pass++;
    errs = 0;
    if (ram[12'hFFE] !== 8'hC3) errs++;
    if (ram[12'hFFF] !== 8'hC3) errs++;
    if (ram[12'h000] !== 8'hC3) errs++;
    if (ram[12'h001] !== 8'hC3) errs++;
    if (ram[12'h002] !== pat(2)) errs++;
    if (ram[12'hFFD] !== pat(4093)) errs++;
    n_checks++;
    if (errs != 0) $display("FAIL wrap_mem: got %0d bad bytes want 0", errs); else n_pass++;
    io_read(3'd2, d);
    n_checks++;
    if (d !== 8'h02) $display("FAIL wrap_dst_l: got %h want 02", d); else n_pass++;
    io_read(3'd3, d);
    n_checks++;
    if (d !== 8'h00) $display("FAIL wrap_dst_h: got %h want 00", d); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int n;
    int errs;
    logic [7:0] d;
    load_pattern();
    set_regs(12'h000, 12'h200, 12'd20, 8'h11);
    io_write(3'd7, 8'h02);
    io_write(3'd6, 8'h99);
    io_write(3'd7, 8'h01);
    wait_done(100, n);
    n_checks++;
    if (n >= 100) $display("FAIL busy_ign_timeout: got %0d want <100", n); else n_pass++;
    io_read(3'd6, d);
    n_checks++;
    if (d !== 8'h11) $display("FAIL busy_ign_fill: got %h want 11", d); else n_pass++;
    errs = 0;
    for (int i = 12'h200; i < 12'h214; i++) if (ram[i] !== 8'h11) errs++;
    if (ram[12'h214] !== pat(12'h214)) errs++;
    n_checks++;
    if (errs != 0) $display("FAIL busy_ign_mem: got %0d bad bytes want 0", errs); else n_pass++;
  endtask

  task automatic test_abort();
    int errs;
    logic [7:0] d;
    load_pattern();
    set_regs(12'h050, 12'h000, 12'd3920, 8'h00);
    io_write(3'd7, 8'h01);
    // Ten bytes finish at the 20th edge after start; the abort lands on the 21st.
    repeat (19) @(negedge clock);
    io_write(3'd7, 8'h04);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1)
      $display("FAIL abort_state: got busy %b done %b want 0 1", busy, done);
    else n_pass++;
    io_read(3'd4, d);
    n_checks++;
    if (d !== 8'h46) $display("FAIL abort_len_l: got %h want 46", d); else n_pass++;
    io_read(3'd5, d);
    n_checks++;
    if (d !== 8'h0F) $display("FAIL abort_len_h: got %h want 0f", d); else n_pass++;
    io_read(3'd0, d);
    n_checks++;
    if (d !== 8'h5A) $display("FAIL abort_src_l: got %h want 5a", d); else n_pass++;
    errs = 0;
    for (int i = 0; i < 10; i++) if (ram[i] !== pat(i + 80)) errs++;
    if (ram[10] !== pat(10)) errs++;
    n_checks++;
    if (errs != 0) $display("FAIL abort_mem: got %0d bad bytes want 0", errs); else n_pass++;
    @(negedge clock);
    n_checks++;
    if (done !== 1'b0) $display("FAIL abort_pulse: got %b want 0", done); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dones;
    logic [7:0] d;
    set_regs(12'h000, 12'h100, 12'd100, 8'hEE);
    io_write(3'd7, 8'h02);
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
    for (int r = 0; r < 8; r++) begin
      io_read(3'(r), d);
      n_checks++;
      if (d !== 8'h00) $display("FAIL rstmid_reg%0d: got %h want 00", r, d); else n_pass++;
    end
    dones = 0;
    repeat (120) begin
      @(negedge clock);
      if (done === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 0) $display("FAIL rstmid_done: got %0d pulses want 0", dones); else n_pass++;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    init_req   = 1'b0;
    reset_n    = 1'b0;
    io_address = 16'h0000;
    io_wren    = 1'b0;
    io_data    = 8'h00;
    cpu_req    = 1'b0;
    cpu_addr   = '0;
    cpu_wren   = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    test_reset();
    test_regs();
    test_len_zero();
    test_fill();
    test_copy();
    test_copy_contended();
    test_wrap();
    test_busy_ignore();
    test_abort();
    test_reset_mid();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
